sm_arbiter: RTL and testbench
=============================

# sm_arbiter

Two-port arbiter and sequencer that shares one sequential shift-add multiplier between two requesters. It captures a requester's operands, loads the multiplier, and pulses its start. It then waits for the multiplier's done and returns the product to the requester that owns the operation. A watchdog counter aborts a multiplication that never completes, and reports an error to the owner.

## Interface
- W, 4, operand width; product width is 2W
- TIMEOUT, 31, max WAIT cycles before abort (1..255)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  level request from requester 0/1
- a0, b0, a1, b1  in  W  multiplicand/multiplier of requester 0/1, stable while req high
- ack0, ack1  out  1  one-cycle pulse: operands captured, req may drop
- done0, done1  out  1  one-cycle pulse: result for requester 0/1 valid
- product0, product1  out  2W  registered result, updated only on own done, held otherwise
- err0, err1  out  1  timeout flag, valid with done, held with product
- sm_md, sm_mr  out  W  operands to multiplier, registered
- sm_start  out  1  one-cycle start pulse to multiplier
- sm_clr  out  1  one-cycle multiplier reset pulse on timeout
- sm_done  in  1  multiplier done (pulse or level accepted)
- sm_product  in  2W  multiplier running-sum result, valid when sm_done
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: req0/req1 are sampled only here. One request high → grant it. Both high → grant the requester not granted last (`last` register; reset value 1, so requester 0 wins the first tie).
- On grant: owner<=i, sm_md<=a_i, sm_mr<=b_i, ack_i<=1, go START.
- START: sm_start=1 for exactly this cycle; the cycle counter is cleared; go WAIT.
- WAIT: counter increments each cycle, saturating at TIMEOUT.
  - sm_done high → product_owner<=sm_product, err_owner<=0, go RESP.
  - else counter==TIMEOUT → product_owner<=0, err_owner<=1, sm_clr=1 (single cycle), go RESP.
  - sm_done and counter==TIMEOUT in the same cycle → done wins (no error).
- RESP: done_owner=1 for this cycle; last<=owner; go IDLE.
- sm_done is ignored outside WAIT (stale level from the previous op has no effect).
- A req that is still high after done is treated as a new request at the next IDLE sample.
- Non-owner product/err/done are never disturbed.
- Product width is 2W; no truncation. Operands of 0 are legal (product 0).

## Timing
- Reset (rst low, async): state IDLE, all outputs 0 (ack, done, err, product, sm_md, sm_mr, sm_start, sm_clr, busy), last=1, counter=0, owner=0.
- Reset asserted mid-operation: abandons it with no done pulse; the requester must re-request. Deassertion is synchronized by the normal edge; first grant can occur on the first edge after release.
- Request high at edge T (IDLE) → ack and busy high after T+1 (START), sm_start high during the START cycle.
- Multiplier done seen in WAIT cycle k → done_i high one cycle later (RESP), back in IDLE the cycle after.
- Minimum issue-to-issue spacing: 4 cycles (IDLE, START, WAIT, RESP) plus multiplier latency.
- Timeout: done_i with err_i=1 appears TIMEOUT+1 cycles after START if sm_done is never seen; sm_clr is pulsed in the last WAIT cycle.
- ack_i, done_i, sm_start, sm_clr are never high for more than one consecutive cycle.

## Test plan
- Single request: req0=1, a0=4'd13, b0=4'd11, multiplier model returns after 10 cycles → ack0 one cycle, sm_md=13, sm_mr=11, one sm_start, done0 with product0=8'd143, err0=0; requester 1 outputs untouched.
- Tie and round-robin: req0=req1=1 held through three ops → grant order 0,1,0; each done pairs with the correct product (a0=3,b0=5 → 15; a1=15,b1=15 → 225).
- Timeout: model never raises sm_done, TIMEOUT=31 → sm_clr one pulse, done1 with err1=1, product1=0, 32 cycles after START; the next request completes normally with err cleared.
- Stale done: sm_done held high through IDLE/START → ignored; product is captured only on sm_done seen in WAIT; done coinciding with counter==TIMEOUT gives err=0.
- Async reset mid-WAIT: rst low while owner=1 → all outputs 0 immediately, no done1; after release, req1 re-grants and completes (a1=0,b1=9 → 0).

Source files
------------

// File: rtl/sm_arbiter.sv
// rtl/sm_arbiter.sv - two-port arbiter sharing one sequential multiplier, with watchdog abort
module sm_arbiter #(
    parameter int W       = 4,
    parameter int TIMEOUT = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic           done0,
    output logic           done1,
    output logic [2*W-1:0] product0,
    output logic [2*W-1:0] product1,
    output logic           err0,
    output logic           err1,
    output logic [W-1:0]   sm_md,
    output logic [W-1:0]   sm_mr,
    output logic           sm_start,
    output logic           sm_clr,
    input  logic           sm_done,
    input  logic [2*W-1:0] sm_product,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] cnt;
    logic       owner;
    logic       last;
    logic       pick1;
    logic       at_limit;

    // Tie goes to whoever was not served last.
    assign pick1    = req1 && !(req0 && last);
    // cnt counts WAIT cycles including the current one, so the abort lands after TIMEOUT WAIT cycles.
    assign at_limit = (cnt == LIMIT);
    assign sm_clr   = (state == WAIT) && at_limit && !sm_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            owner    <= 1'b0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            product0 <= '0;
            product1 <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            sm_md    <= '0;
            sm_mr    <= '0;
            sm_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            sm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner    <= pick1;
                        sm_md    <= pick1 ? a1 : a0;
                        sm_mr    <= pick1 ? b1 : b0;
                        ack0     <= !pick1;
                        ack1     <= pick1;
                        sm_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= 8'd1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (sm_done || at_limit) begin
                        if (owner) begin
                            product1 <= sm_done ? sm_product : '0;
                            err1     <= !sm_done;
                            done1    <= 1'b1;
                        end else begin
                            product0 <= sm_done ? sm_product : '0;
                            err0     <= !sm_done;
                            done0    <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_arbiter.sv
// tb/tb_sm_arbiter.sv - vector table, corner sequences and random ops against a spec-level model
module tb_sm_arbiter;

    localparam int W  = 4;
    localparam int TO = 31;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         ack0, ack1, done0, done1, err0, err1;
    logic [7:0]   product0, product1;
    logic [W-1:0] sm_md, sm_mr;
    logic         sm_start, sm_clr, busy;
    logic         sm_done = 1'b0;
    logic [7:0]   sm_product = '0;

    sm_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .product0(product0), .product1(product1), .err0(err0), .err1(err1),
        .sm_md(sm_md), .sm_mr(sm_mr), .sm_start(sm_start), .sm_clr(sm_clr),
        .sm_done(sm_done), .sm_product(sm_product), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int last_m = 1;
    logic [7:0] mprod [2];
    logic       merr  [2];

    typedef struct {
        logic       r0, r1;
        logic [3:0] va0, vb0, va1, vb1;
        int         lat;
        bit         level;
        int         eo;
        logic [7:0] ep;
        logic       ee;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, 32'({ack0, ack1, done0, done1, err0, err1, sm_start, sm_clr, busy}), 32'(0));
        chk({tag, "_prods"}, 32'({product0, product1}), 32'(0));
        chk({tag, "_ops"}, 32'({sm_md, sm_mr}), 32'(0));
    endtask

    // Drives one operation from grant to return-to-idle; lat = WAIT cycle in which the
    // multiplier raises sm_done (beyond TO means never). level keeps sm_done high afterwards.
    task automatic run_op(input int lat, input bit level, input int eo,
                          input logic [7:0] ep, input logic ee);
        int n;
        int td;
        logic [3:0] md, mr;
        n = 0;
        @(negedge clk);
        while (!sm_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_latency", 32'(n), 32'(0));
        if (!sm_start) return;
        chk("ack", 32'({ack0, ack1}), (eo == 0) ? 32'(2) : 32'(1));
        chk("busy_start", 32'(busy), 32'(1));
        chk("sm_md", 32'(sm_md), (eo == 0) ? 32'(a0) : 32'(a1));
        chk("sm_mr", 32'(sm_mr), (eo == 0) ? 32'(b0) : 32'(b1));
        md = sm_md;
        mr = sm_mr;
        sm_done = 1'b0;
        td = (lat <= TO) ? lat + 1 : TO + 1;
        for (int c = 1; c <= td; c++) begin
            @(negedge clk);
            if (c == lat) begin
                sm_done    = 1'b1;
                sm_product = 8'(md) * 8'(mr);
            end else if (!level) begin
                sm_done = 1'b0;
            end
            #1;
            if (c < td) begin
                chk("wait_quiet", 32'({done0, done1, ack0, ack1, sm_start}), 32'(0));
                chk("sm_clr", 32'(sm_clr), 32'(lat > TO && c == TO));
            end
        end
        mprod[eo] = ep;
        merr[eo]  = ee;
        last_m    = eo;
        chk("done", 32'({done0, done1}), (eo == 0) ? 32'(2) : 32'(1));
        chk("product0", 32'(product0), 32'(mprod[0]));
        chk("product1", 32'(product1), 32'(mprod[1]));
        chk("err", 32'({err0, err1}), 32'({merr[0], merr[1]}));
        chk("resp_clr", 32'(sm_clr), 32'(0));
        @(negedge clk);
        chk("idle_after", 32'({done0, done1, busy, sm_clr, sm_start}), 32'(0));
    endtask

    initial begin
        mprod[0] = '0; mprod[1] = '0; merr[0] = 1'b0; merr[1] = 1'b0;
        tbl[0] = '{1, 1, 3, 5, 15, 15, 3, 0, 0, 8'd15, 0};
        tbl[1] = '{1, 1, 3, 5, 15, 15, 3, 0, 1, 8'd225, 0};
        tbl[2] = '{1, 1, 3, 5, 15, 15, 3, 0, 0, 8'd15, 0};
        tbl[3] = '{1, 0, 13, 11, 0, 0, 10, 0, 0, 8'd143, 0};
        tbl[4] = '{0, 1, 0, 0, 7, 6, 99, 0, 1, 8'd0, 1};
        tbl[5] = '{0, 1, 0, 0, 7, 6, 2, 0, 1, 8'd42, 0};
        tbl[6] = '{1, 0, 2, 9, 0, 0, 4, 1, 0, 8'd18, 0};
        tbl[7] = '{0, 1, 0, 0, 5, 5, 31, 0, 1, 8'd25, 0};
        tbl[8] = '{1, 0, 9, 9, 0, 0, 32, 0, 0, 8'd0, 1};
        tbl[9] = '{1, 0, 0, 0, 0, 0, 30, 0, 0, 8'd0, 0};

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            a0 = tbl[i].va0; b0 = tbl[i].vb0; a1 = tbl[i].va1; b1 = tbl[i].vb1;
            run_op(tbl[i].lat, tbl[i].level, tbl[i].eo, tbl[i].ep, tbl[i].ee);
        end
        req0 = 1'b0; req1 = 1'b0; sm_done = 1'b0;

        // Async reset while requester 1 is waiting on the multiplier.
        @(negedge clk);
        req1 = 1'b1; a1 = 4'd0; b1 = 4'd9;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'(1));
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_in_reset", 32'({done0, done1, busy}), 32'(0));
        end
        last_m = 1; mprod[0] = '0; mprod[1] = '0; merr[0] = 1'b0; merr[1] = 1'b0;
        rst = 1'b1;
        run_op(5, 0, 1, 8'd0, 1'b0);
        req1 = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic r0, r1;
            int   lat, eo;
            logic [7:0] ep;
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            req0 = r0; req1 = r1;
            a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            lat = $urandom_range(1, 35);
            eo = (r0 && r1) ? ((last_m == 1) ? 0 : 1) : (r0 ? 0 : 1);
            if (lat > TO) ep = 8'd0;
            else if (eo == 0) ep = 8'(int'(a0) * int'(b0));
            else ep = 8'(int'(a1) * int'(b1));
            run_op(lat, 0, eo, ep, 1'(lat > TO));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_idle", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
